// File: rtl/xadc_byte_framer.sv
// Buffers XADC sample writes and row-start markers in a small FIFO and serializes
// them into a 0xFF-delimited byte stream whose data bytes never reach 0xFF.
`timescale 1ns/1ps
module xadc_byte_framer #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              DCLK,
  input  logic              RESET,
  input  logic              tx_fifo_wr,
  input  logic [11:0]       tx_fifo_data,
  input  logic              chang_row_en,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_HI   = 2'd2,
    S_LO   = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(FIFO_DEPTH);

  logic [12:0]       mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  state_t            state_r;
  state_t            state_s;
  logic [11:0]       hold_r;
  logic [11:0]       hold_s;
  logic              ovf_r;
  logic [7:0]        drop_r;
  logic [7:0]        tx_data_r;
  logic              tx_valid_r;
  logic              push_req_s;
  logic              push_ok_s;
  logic              collide_s;
  logic              reject_s;
  logic              pop_s;
  logic [12:0]       push_entry_s;
  logic [12:0]       head_s;
  logic [1:0]        drop_inc_s;
  logic [8:0]        drop_sum_s;
  logic [7:0]        drop_s;

  // Byte presented for a given serializer state; idle drives zero.
  function automatic logic [7:0] encode_byte(input state_t st, input logic [11:0] v);
    case (st)
      S_HDR:   encode_byte = 8'hFF;
      S_HI:    encode_byte = {2'b01, v[11:6]};
      S_LO:    encode_byte = {2'b00, v[5:0]};
      default: encode_byte = 8'h00;
    endcase
  endfunction

  // Push arbitration, full check and drop accounting (a header+sample collision
  // always costs the sample; a full FIFO additionally rejects the winner).
  always_comb begin
    push_req_s = chang_row_en | tx_fifo_wr;
    collide_s  = chang_row_en & tx_fifo_wr;
    reject_s   = push_req_s & (level_r >= DEPTH_L);
    push_ok_s  = push_req_s & ~reject_s;
    if (chang_row_en) begin
      push_entry_s = {1'b1, 12'h000};
    end else begin
      push_entry_s = {1'b0, tx_fifo_data};
    end
    drop_inc_s = {1'b0, collide_s} + {1'b0, reject_s};
    drop_sum_s = {1'b0, drop_r} + {7'd0, drop_inc_s};
    if (drop_sum_s > 9'd255) begin
      drop_s = 8'd255;
    end else begin
      drop_s = drop_sum_s[7:0];
    end
  end

  // Serializer next state; the pop happens only from idle.
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    pop_s   = 1'b0;
    head_s  = mem_r[rd_ptr_r];
    case (state_r)
      S_IDLE: begin
        if (level_r != {(ADDR_W+1){1'b0}}) begin
          pop_s   = 1'b1;
          hold_s  = head_s[11:0];
          state_s = head_s[12] ? S_HDR : S_HI;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HDR: begin
        if (tx_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_HDR;
        end
      end
      S_HI: begin
        if (tx_ready) begin
          state_s = S_LO;
        end else begin
          state_s = S_HI;
        end
      end
      S_LO: begin
        if (tx_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_LO;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers are flushed.
  always_ff @(posedge DCLK) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_entry_s;
    end
  end

  // Pointers, occupancy and sticky drop bookkeeping.
  always_ff @(posedge DCLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= {(ADDR_W+1){1'b0}};
      ovf_r    <= 1'b0;
      drop_r   <= 8'd0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   level_r <= level_r + (ADDR_W+1)'(1);
        2'b01:   level_r <= level_r - (ADDR_W+1)'(1);
        default: level_r <= level_r;
      endcase
      if (drop_inc_s != 2'd0) begin
        ovf_r <= 1'b1;
      end
      drop_r <= drop_s;
    end
  end

  // Serializer state, holding register and registered byte outputs
  // (outputs are loaded from the next state so they match the state decode).
  always_ff @(posedge DCLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= S_IDLE;
      hold_r     <= 12'h000;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_r     <= hold_s;
      tx_data_r  <= encode_byte(state_s, hold_s);
      tx_valid_r <= (state_s != S_IDLE);
    end
  end

  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign fifo_level = level_r;
  assign overflow   = ovf_r;
  assign drop_cnt   = drop_r;

endmodule

// File: tb/tb_xadc_byte_framer.sv
// Directed and randomized checks of xadc_byte_framer against a byte-stream
// reference built from the framing rules (header 0xFF, 0x40+hi6, lo6).
`timescale 1ns/1ps
module tb_xadc_byte_framer;

  logic        DCLK = 1'b0;
  logic        RESET;
  logic        tx_fifo_wr;
  logic [11:0] tx_fifo_data;
  logic        chang_row_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [11:0] v;
  logic [11:0] first_v;

  xadc_byte_framer #(.FIFO_DEPTH(16), .ADDR_W(4)) dut (
    .DCLK(DCLK), .RESET(RESET), .tx_fifo_wr(tx_fifo_wr), .tx_fifo_data(tx_fifo_data),
    .chang_row_en(chang_row_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 DCLK = ~DCLK;

  // Inputs are stable from posedge+1 to the next posedge, so a negedge sample
  // tells exactly whether the coming edge performs a transfer.
  always @(negedge DCLK) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) got_q.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge DCLK);
    #1;
  endtask

  task automatic exp_sample(input logic [11:0] s);
    exp_q.push_back(8'h40 + 8'(s / 64));
    exp_q.push_back(8'(s % 64));
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    tx_fifo_wr = 1'b0; chang_row_en = 1'b0; tx_fifo_data = 12'h000; tx_ready = 1'b0;
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    tick();
    clear_q();
  endtask

  task automatic drain(input string tag, input bit rand_ready, input int budget);
    int c = 0;
    while (got_q.size() < exp_q.size() && c < budget) begin
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      c++;
    end
    tx_ready = 1'b1;
    repeat (4) tick();
    chk({tag, " byte count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s byte %0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, " level empty"}, fifo_level, 5'd0);
    chk({tag, " valid low"}, tx_valid, 1'b0);
    clear_q();
  endtask

  initial begin
    tx_fifo_wr = 1'b0; chang_row_en = 1'b0; tx_fifo_data = 12'h000; tx_ready = 1'b0;
    RESET = 1'b1;
    tick(); tick();
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst level", fifo_level, 5'd0);
    chk("rst overflow", overflow, 1'b0);
    chk("rst drop_cnt", drop_cnt, 8'd0);
    RESET = 1'b0;
    tick();
    clear_q();

    // Single sample: cycle-exact latency and duration
    tx_ready = 1'b1; tx_fifo_wr = 1'b1; tx_fifo_data = 12'hABC;
    tick();
    tx_fifo_wr = 1'b0;
    chk("single level1", fifo_level, 5'd1);
    chk("single valid n+1", tx_valid, 1'b0);
    tick();
    chk("single valid n+2", tx_valid, 1'b1);
    chk("single hi", tx_data, 8'h6A);
    chk("single level0", fifo_level, 5'd0);
    tick();
    chk("single valid n+3", tx_valid, 1'b1);
    chk("single lo", tx_data, 8'h3C);
    tick();
    chk("single valid n+4", tx_valid, 1'b0);
    exp_sample(12'hABC);
    drain("single", 1'b0, 20);

    // Header followed by extreme samples
    chang_row_en = 1'b1; tick(); chang_row_en = 1'b0;
    tx_fifo_wr = 1'b1; tx_fifo_data = 12'h000; tick();
    tx_fifo_data = 12'hFFF; tick(); tx_fifo_wr = 1'b0;
    exp_q.push_back(8'hFF); exp_sample(12'h000); exp_sample(12'hFFF);
    drain("hdr", 1'b0, 40);

    // Backpressure: byte held stable
    tx_ready = 1'b0; tx_fifo_wr = 1'b1; tx_fifo_data = 12'h123; tick();
    tx_fifo_wr = 1'b0; tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp valid %0d", i), tx_valid, 1'b1);
      chk($sformatf("bp data %0d", i), tx_data, 8'h44);
      tick();
    end
    exp_sample(12'h123);
    drain("bp", 1'b0, 20);

    // Simultaneous header and sample: sample is lost
    do_reset();
    tx_ready = 1'b1; chang_row_en = 1'b1; tx_fifo_wr = 1'b1; tx_fifo_data = 12'h555;
    tick();
    chang_row_en = 1'b0; tx_fifo_wr = 1'b0;
    chk("simul drop_cnt", drop_cnt, 8'd1);
    chk("simul overflow", overflow, 1'b1);
    exp_q.push_back(8'hFF);
    drain("simul", 1'b0, 20);

    // Overflow: 20 back-to-back pushes with the sink stalled
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      v = 12'($urandom);
      tx_fifo_wr = 1'b1; tx_fifo_data = v;
      if (i < 17) exp_sample(v);
      tick();
    end
    tx_fifo_wr = 1'b0;
    tick();
    chk("ovf level", fifo_level, 5'd16);
    chk("ovf drop_cnt", drop_cnt, 8'd3);
    chk("ovf overflow", overflow, 1'b1);
    chk("ovf valid", tx_valid, 1'b1);
    chk("ovf first byte", tx_data, exp_q[0]);
    drain("ovf", 1'b0, 200);

    // Randomized rows with random sink readiness
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(3, 10);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          chang_row_en = 1'b1;
          exp_q.push_back(8'hFF);
        end else begin
          v = 12'($urandom);
          tx_fifo_wr = 1'b1; tx_fifo_data = v;
          exp_sample(v);
        end
        tx_ready = 1'($urandom_range(0, 1));
        tick();
        chang_row_en = 1'b0; tx_fifo_wr = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          tx_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      drain($sformatf("rand%0d", r), 1'b1, 400);
    end
    chk("rand drop_cnt kept", drop_cnt, 8'd3);
    chk("rand overflow kept", overflow, 1'b1);

    // Reset while in the low-byte state with 5 entries queued
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = 12'($urandom);
      if (i == 0) first_v = v;
      tx_fifo_wr = 1'b1; tx_fifo_data = v;
      tick();
    end
    tx_fifo_wr = 1'b0; tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("midrst in lo valid", tx_valid, 1'b1);
    chk("midrst in lo data", tx_data, 8'(first_v % 64));
    chk("midrst queued", fifo_level, 5'd5);
    #2 RESET = 1'b1;
    #1;
    chk("midrst async valid", tx_valid, 1'b0);
    chk("midrst async data", tx_data, 8'h00);
    chk("midrst async level", fifo_level, 5'd0);
    chk("midrst async overflow", overflow, 1'b0);
    chk("midrst async drop", drop_cnt, 8'd0);
    tick(); tick();
    RESET = 1'b0;
    clear_q();
    tx_ready = 1'b1;
    repeat (10) tick();
    chk("midrst no bytes", got_q.size(), 0);
    chk("midrst idle valid", tx_valid, 1'b0);
    v = 12'($urandom);
    tx_fifo_wr = 1'b1; tx_fifo_data = v; tick(); tx_fifo_wr = 1'b0;
    exp_sample(v);
    drain("postrst", 1'b0, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xadc_byte_framer.md
# xadc_byte_framer

Downstream stage of the XADC register reader. It accepts the reader's 12-bit sample writes (`tx_fifo_wr`/`tx_fifo_data`) and its one-cycle row-change pulse (`chang_row_en`), and buffers them in an internal FIFO. It then serializes them into an unambiguous byte stream for the UART transmitter: a 0xFF header per row, then two 7-bit-safe bytes per sample. It isolates the bursty DRP read rate from the slow UART byte rate and accounts for any data it has to drop.

## Interface
- `FIFO_DEPTH`, 16, number of entries; power of two, ≥4.
- `ADDR_W`, 4, log2(`FIFO_DEPTH`).
- `DCLK` in 1: the single clock, 50 MHz DRP domain.
- `RESET` in 1: asynchronous, active-high reset.
- `tx_fifo_wr` in 1: sample write strobe, one cycle per sample.
- `tx_fifo_data` in 12: sample value, valid with `tx_fifo_wr`.
- `chang_row_en` in 1: row-start pulse; enqueues one header entry.
- `tx_data` out 8: byte presented to the UART.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: UART accepts a byte; a transfer occurs when `tx_valid && tx_ready`.
- `fifo_level` out ADDR_W+1: current number of occupied entries.
- `overflow` out 1: sticky; set on any dropped entry.
- `drop_cnt` out 8: count of dropped entries, saturating at 255.

## Operation
- **FIFO entries.** Each entry is 13 bits, `{is_hdr, data[11:0]}`. A header entry stores `is_hdr`=1 and data=0.
- **Push.**
  - `chang_row_en`=1 pushes a header entry. Otherwise `tx_fifo_wr`=1 pushes `{0, tx_fifo_data}`.
  - If both are high in the same cycle, the header wins. The sample is dropped and counted as a drop.
- **Full check.** A push is accepted only if the registered `fifo_level` < `FIFO_DEPTH`. A pop in the same cycle does not free room for that push.
  - A rejected push sets `overflow` and increments `drop_cnt` (saturating).
- **Pointers.** Write and read pointers are ADDR_W bits and wrap modulo `FIFO_DEPTH`.
  - `fifo_level` is +1 on an accepted push, -1 on a pop, and unchanged when both happen in the same cycle.
- **Serializer FSM.** States are S_IDLE, S_HDR, S_HI, S_LO.
  - S_IDLE: if `fifo_level`≠0, pop the head into the holding register `hold`, then go to S_HDR if `is_hdr`, else S_HI. Otherwise stay in S_IDLE.
  - S_HDR: `tx_data`=8'hFF. On a transfer, go to S_IDLE.
  - S_HI: `tx_data`={2'b01, hold[11:6]} (range 0x40–0x7F). On a transfer, go to S_LO.
  - S_LO: `tx_data`={2'b00, hold[5:0]} (range 0x00–0x3F). On a transfer, go to S_IDLE.
  - `tx_valid` = (state ≠ S_IDLE). `tx_valid` and `tx_data` are decoded only from the registered state and `hold`, so they stay stable until the transfer.
- **Encoding.** A data byte never equals 0xFF, and high and low bytes are distinguished by bit 6.
- **Reset values.** All outputs are 0; state=S_IDLE; pointers, `fifo_level`, `overflow` and `drop_cnt` are 0.
  - Reset mid-byte abandons the byte and flushes the FIFO.
- `overflow` and `drop_cnt` clear only on `RESET`.

## Timing
- Push in cycle N makes `fifo_level` update at the edge ending N.
  - S_IDLE pops in N+1.
  - `tx_valid`=1 with the first byte from N+2, so the first-byte latency is 2 cycles.
- Per entry: the serializer spends one S_IDLE cycle between entries. With `tx_ready` held at 1:
  - a sample takes 3 cycles (HI, LO, IDLE);
  - a header takes 2 cycles.
- The FIFO read is registered into `hold` on the pop edge. There is no combinational path from `tx_ready` to FIFO storage.
- Every `tx_ready` that is not coincident with `tx_valid` is ignored.
- Back-to-back `tx_fifo_wr` every cycle is accepted until the FIFO is full.

## Test plan
- **Single sample.** Push 12'hABC with `tx_ready`=1. Expect bytes 0x6A then 0x3C, `tx_valid` high for exactly 2 cycles starting 2 cycles after the push, and `fifo_level` back to 0.
- **Header plus samples.** Pulse `chang_row_en`, then push 12'h000 and 12'hFFF. Expect the byte sequence 0xFF, 0x40, 0x00, 0x7F, 0x3F in order.
- **Backpressure.** Push 12'h123 and hold `tx_ready`=0 for 10 cycles. Expect `tx_data`=0x44 stable with `tx_valid`=1 throughout. Then release and expect 0x44, 0x23.
- **Overflow.** Hold `tx_ready`=0 and push 20 samples back-to-back.
  - Expect `fifo_level`=16 (or 15 plus one in `hold`, per pop timing).
  - Expect total dropped = 20 − 17 = 3 after the first pop: `drop_cnt`=3 and `overflow`=1.
  - After releasing `tx_ready`, expect exactly 17 samples output in order.
- **Simultaneous events.** Raise `chang_row_en` and `tx_fifo_wr` with 12'h555 in the same cycle. Expect only 0xFF to be emitted, `drop_cnt`=1, and `overflow`=1.
- **Reset mid-operation.** Assert `RESET` asynchronously while in S_LO with 5 entries queued. Expect all outputs at 0 immediately, and no further bytes after release until a new push.
